// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter that serialises I-cache refills and D-cache refill/writeback
// line bursts onto a single word-wide main-memory port.
module mem_refill_arbiter #(
    parameter int unsigned BEATS = 4,
    localparam int unsigned BW   = $clog2(BEATS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // Instruction cache (read-only)
    input  logic          i_ic_req,
    input  logic [31:0]   i_ic_addr,
    output logic [31:0]   o_ic_rdata,
    output logic          o_ic_rvalid,
    output logic          o_ic_done,
    // Data cache (refill or writeback)
    input  logic          i_dc_req,
    input  logic          i_dc_we,
    input  logic [31:0]   i_dc_addr,
    input  logic [31:0]   i_dc_wdata,
    output logic [BW-1:0] o_dc_beat,
    output logic [31:0]   o_dc_rdata,
    output logic          o_dc_rvalid,
    output logic          o_dc_done,
    // Main memory
    output logic          o_mm_req,
    output logic          o_mm_we,
    output logic [31:0]   o_mm_addr,
    output logic [31:0]   o_mm_wdata,
    input  logic          i_mm_ack,
    input  logic [31:0]   i_mm_rdata
);

    // Byte-offset bits within one line; cleared to form the burst base address.
    localparam logic [31:0] LineMask = 32'(BEATS * 4 - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StFinish} state_t;

    state_t        r_state, w_state_d;
    logic [BW-1:0] r_beat, w_beat_d;
    logic          r_last_dc, w_last_dc_d;   // last completed owner was DC
    logic          r_owner_dc, w_owner_dc_d; // current burst owner is DC
    logic          r_we, w_we_d;
    logic [31:0]   r_base, w_base_d;
    logic          w_grant_dc;

    // On a tie the DC wins unless it was the last owner.
    assign w_grant_dc = i_dc_req && (!i_ic_req || !r_last_dc);
    assign o_dc_beat  = r_beat;

    // State and burst-context registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_beat     <= '0;
            r_last_dc  <= 1'b0;
            r_owner_dc <= 1'b0;
            r_we       <= 1'b0;
            r_base     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_beat     <= w_beat_d;
            r_last_dc  <= w_last_dc_d;
            r_owner_dc <= w_owner_dc_d;
            r_we       <= w_we_d;
            r_base     <= w_base_d;
        end
    end

    // Next-state, grant latching and memory/cache-side outputs.
    always_comb begin
        w_state_d    = r_state;
        w_beat_d     = r_beat;
        w_last_dc_d  = r_last_dc;
        w_owner_dc_d = r_owner_dc;
        w_we_d       = r_we;
        w_base_d     = r_base;
        o_mm_req     = 1'b0;
        o_mm_we      = 1'b0;
        o_mm_addr    = '0;
        o_mm_wdata   = '0;
        o_ic_rvalid  = 1'b0;
        o_dc_rvalid  = 1'b0;
        o_ic_done    = 1'b0;
        o_dc_done    = 1'b0;
        o_ic_rdata   = '0;
        o_dc_rdata   = '0;

        unique case (r_state)
            StIdle: begin
                if (i_ic_req || i_dc_req) begin
                    w_owner_dc_d = w_grant_dc;
                    w_we_d       = w_grant_dc && i_dc_we;
                    w_base_d     = (w_grant_dc ? i_dc_addr : i_ic_addr) & ~LineMask;
                    w_beat_d     = '0;
                    w_state_d    = StBurst;
                end
            end
            StBurst: begin
                o_mm_req   = 1'b1;
                o_mm_we    = r_we;
                o_mm_addr  = r_base + {{(30 - BW){1'b0}}, r_beat, 2'b00};
                o_mm_wdata = (r_owner_dc && r_we) ? i_dc_wdata : '0;
                if (i_mm_ack) begin
                    o_ic_rvalid = !r_owner_dc && !r_we;
                    o_dc_rvalid = r_owner_dc && !r_we;
                    if (r_beat == BW'(BEATS - 1)) begin
                        w_beat_d  = '0;
                        w_state_d = StFinish;
                    end else begin
                        w_beat_d = r_beat + 1'b1;
                    end
                end
            end
            StFinish: begin
                o_ic_done   = !r_owner_dc;
                o_dc_done   = r_owner_dc;
                w_last_dc_d = r_owner_dc;
                w_state_d   = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        if (o_ic_rvalid) o_ic_rdata = i_mm_rdata;
        if (o_dc_rvalid) o_dc_rdata = i_mm_rdata;
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: directed scenarios plus random bursts,
// checked against a transaction-level model of line bursts and round-robin grants.
module tb_mem_refill_arbiter;

    localparam int unsigned BEATS = 4;
    localparam int unsigned BW    = $clog2(BEATS);
    localparam logic [31:0] LineMask = 32'(BEATS * 4 - 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req, dc_req, dc_we, mm_ack;
    logic [31:0]   ic_addr, dc_addr, dc_wdata, mm_rdata;
    logic [31:0]   ic_rdata, dc_rdata, mm_addr, mm_wdata;
    logic          ic_rvalid, ic_done, dc_rvalid, dc_done, mm_req, mm_we;
    logic [BW-1:0] dc_beat;

    int checks = 0;
    int errors = 0;
    bit m_last_dc;  // model: last completed burst belonged to DC

    always #5 clk = ~clk;

    mem_refill_arbiter #(.BEATS(BEATS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ic_req   (ic_req),
        .i_ic_addr  (ic_addr),
        .o_ic_rdata (ic_rdata),
        .o_ic_rvalid(ic_rvalid),
        .o_ic_done  (ic_done),
        .i_dc_req   (dc_req),
        .i_dc_we    (dc_we),
        .i_dc_addr  (dc_addr),
        .i_dc_wdata (dc_wdata),
        .o_dc_beat  (dc_beat),
        .o_dc_rdata (dc_rdata),
        .o_dc_rvalid(dc_rvalid),
        .o_dc_done  (dc_done),
        .o_mm_req   (mm_req),
        .o_mm_we    (mm_we),
        .o_mm_addr  (mm_addr),
        .o_mm_wdata (mm_wdata),
        .i_mm_ack   (mm_ack),
        .i_mm_rdata (mm_rdata)
    );

    // One full line burst starting in the current (idle) cycle. ack_mode: 0 every cycle,
    // 1 every third cycle, 2 random. drop_beat >= 0 drops the owner's request once that
    // many beats are done; abort_beat >= 0 returns early with the burst still running.
    task automatic run_burst(input int ack_mode, input int drop_beat, input int abort_beat,
                             input bit allow_new);
        bit          own_dc, we, ack, dropped;
        logic [31:0] base, exp_addr, exp_wd, exp_icr, exp_dcr;
        logic [5:0]  exp_ctrl;
        int          beat, cyc;
        own_dc  = dc_req && (!ic_req || !m_last_dc);
        we      = own_dc && dc_we;
        base    = (own_dc ? dc_addr : ic_addr) & ~LineMask;
        dropped = 1'b0;
        mm_ack = 1'b1; mm_rdata = $urandom; dc_wdata = $urandom;
        #1;
        checks++;
        if ({mm_req, ic_rvalid, dc_rvalid, ic_done, dc_done} !== 5'b0) begin
            errors++;
            $display("FAIL idle_ctrl: got %b expected 00000",
                     {mm_req, ic_rvalid, dc_rvalid, ic_done, dc_done});
        end
        checks++;
        if (dc_beat !== '0) begin
            errors++; $display("FAIL idle_beat: got %0d expected 0", dc_beat);
        end
        beat = 0; cyc = 0;
        while (beat < BEATS) begin
            @(negedge clk);
            if (beat == abort_beat) return;
            cyc++;
            if (cyc > 200) begin
                checks++; errors++;
                $display("FAIL burst_timeout: got %0d beats expected %0d", beat, BEATS);
                return;
            end
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 3 == 0);
                default: ack = 1'($urandom_range(1, 0));
            endcase
            mm_ack = ack; mm_rdata = $urandom; dc_wdata = $urandom;
            if (drop_beat >= 0 && beat >= drop_beat && !dropped) begin
                dropped = 1'b1;
                if (own_dc) begin dc_req = 1'b0; dc_addr = $urandom; dc_we = ~dc_we; end
                else begin ic_req = 1'b0; ic_addr = $urandom; end
            end
            if (allow_new && $urandom_range(3, 0) == 0) begin
                if (own_dc && !ic_req) begin ic_req = 1'b1; ic_addr = $urandom; end
                else if (!own_dc && !dc_req) begin
                    dc_req = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom_range(1, 0));
                end
            end
            #1;
            exp_ctrl = {1'b1, we, ack && !we && !own_dc, ack && !we && own_dc, 2'b00};
            exp_addr = base + 32'(4 * beat);
            exp_wd   = (own_dc && we) ? dc_wdata : 32'h0;
            exp_icr  = (ack && !own_dc) ? mm_rdata : 32'h0;
            exp_dcr  = (ack && own_dc && !we) ? mm_rdata : 32'h0;
            checks++;
            if ({mm_req, mm_we, ic_rvalid, dc_rvalid, ic_done, dc_done} !== exp_ctrl) begin
                errors++;
                $display("FAIL burst_ctrl: got %b expected %b (beat %0d)",
                         {mm_req, mm_we, ic_rvalid, dc_rvalid, ic_done, dc_done}, exp_ctrl, beat);
            end
            checks++;
            if (mm_addr !== exp_addr) begin
                errors++; $display("FAIL mm_addr: got %h expected %h", mm_addr, exp_addr);
            end
            checks++;
            if (mm_wdata !== exp_wd) begin
                errors++; $display("FAIL mm_wdata: got %h expected %h", mm_wdata, exp_wd);
            end
            checks++;
            if (ic_rdata !== exp_icr) begin
                errors++; $display("FAIL ic_rdata: got %h expected %h", ic_rdata, exp_icr);
            end
            checks++;
            if (dc_rdata !== exp_dcr) begin
                errors++; $display("FAIL dc_rdata: got %h expected %h", dc_rdata, exp_dcr);
            end
            checks++;
            if (dc_beat !== BW'(beat)) begin
                errors++; $display("FAIL dc_beat: got %0d expected %0d", dc_beat, beat);
            end
            if (ack) beat++;
        end
        // Finish cycle: done pulse to the owner, which drops its request here.
        @(negedge clk);
        mm_ack = 1'b1; mm_rdata = $urandom;
        if (own_dc) dc_req = 1'b0; else ic_req = 1'b0;
        #1;
        checks++;
        if ({mm_req, ic_rvalid, dc_rvalid, ic_done, dc_done} !== {3'b000, !own_dc, own_dc}) begin
            errors++;
            $display("FAIL finish_ctrl: got %b expected %b",
                     {mm_req, ic_rvalid, dc_rvalid, ic_done, dc_done}, {3'b000, !own_dc, own_dc});
        end
        checks++;
        if (dc_beat !== '0) begin
            errors++; $display("FAIL finish_beat: got %0d expected 0", dc_beat);
        end
        m_last_dc = own_dc;
    endtask

    // Holds reset for a few cycles with busy inputs; every output must read zero.
    task automatic hold_reset_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            mm_ack = 1'b1; mm_rdata = $urandom; dc_wdata = $urandom;
            #1;
            checks++;
            if ({mm_req, mm_we, ic_rvalid, dc_rvalid, ic_done, dc_done} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl: got %b expected 000000",
                         {mm_req, mm_we, ic_rvalid, dc_rvalid, ic_done, dc_done});
            end
            checks++;
            if ({mm_addr, mm_wdata} !== 64'h0) begin
                errors++; $display("FAIL reset_mm: got %h expected 0", {mm_addr, mm_wdata});
            end
            checks++;
            if ({ic_rdata, dc_rdata} !== 64'h0) begin
                errors++; $display("FAIL reset_rdata: got %h expected 0", {ic_rdata, dc_rdata});
            end
            checks++;
            if (dc_beat !== '0) begin
                errors++; $display("FAIL reset_beat: got %0d expected 0", dc_beat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1; ic_addr = $urandom; dc_addr = $urandom;
        rst_n = 1'b0;
        hold_reset_check(3);
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mm_ack = 1'b0;
        rst_n = 1'b1; m_last_dc = 1'b0;
    endtask

    task automatic test_ic_refill();
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 32'h0000_1234;
        run_burst(0, -1, -1, 1'b0);
    endtask

    task automatic test_tie_alternate();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; m_last_dc = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
            ic_addr = 32'h0000_2000 + 32'(r * 256); dc_addr = 32'h0040_0010 + 32'(r * 256);
            run_burst(0, -1, -1, 1'b0);  // DC wins the tie
            @(negedge clk);
            run_burst(0, -1, -1, 1'b0);  // pending IC follows directly
        end
    endtask

    task automatic test_dc_writeback();
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h8000_0040;
        run_burst(1, -1, -1, 1'b0);
    endtask

    task automatic test_drop_req();
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 32'h0001_0008;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0002_0030;
        run_burst(0, 2, -1, 1'b0);  // IC owns (DC went last), drops after beat 1
        @(negedge clk);
        run_burst(2, -1, -1, 1'b0);
    endtask

    task automatic test_ack_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mm_ack = 1'b1; mm_rdata = $urandom;
            #1;
            checks++;
            if ({mm_req, ic_rvalid, dc_rvalid, ic_done, dc_done} !== 5'b0) begin
                errors++;
                $display("FAIL ack_idle_ctrl: got %b expected 00000",
                         {mm_req, ic_rvalid, dc_rvalid, ic_done, dc_done});
            end
            checks++;
            if (dc_beat !== '0) begin
                errors++; $display("FAIL ack_idle_beat: got %0d expected 0", dc_beat);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0003_0050; ic_req = 1'b0;
        run_burst(0, -1, 3, 1'b0);
        rst_n = 1'b0; ic_req = 1'b1; ic_addr = 32'h0004_0000;
        hold_reset_check(3);
        rst_n = 1'b1; m_last_dc = 1'b0;
        run_burst(0, -1, -1, 1'b0);  // tie after reset: DC first
        @(negedge clk);
        run_burst(0, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ic_req && $urandom_range(1, 0) == 1) begin ic_req = 1'b1; ic_addr = $urandom; end
            if (!dc_req && $urandom_range(1, 0) == 1) begin
                dc_req = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom_range(1, 0));
            end
            if (!ic_req && !dc_req) begin ic_req = 1'b1; ic_addr = $urandom; end
            run_burst(2, ($urandom_range(3, 0) == 0) ? int'($urandom_range(BEATS - 1, 1)) : -1,
                      -1, 1'b1);
        end
        ic_req = 1'b0; dc_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mm_ack = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mm_rdata = '0; m_last_dc = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ic_refill();
        test_tie_alternate();
        test_dc_writeback();
        test_drop_req();
        test_ack_idle();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
